imm_rot_encoder: RTL and testbench
==================================

IMM_ROT_ENCODER -- requirements
Module: Imm_Rot_Encoder

Interface
REQ-001 Parameter: none; all widths fixed (32-bit value, 12-bit Shift_operand, 4-bit rotate, 8-bit immediate).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to encode Value; sampled only in IDLE.
REQ-005 Value  input  32  constant to encode; latched on an accepted start.
REQ-006 Inv_En  input  1  allows the inverted-value fallback pass; latched on an accepted start.
REQ-007 busy  output  1  high while in SEARCH.
REQ-008 done  output  1  one-cycle pulse when the result is valid.
REQ-009 ok  output  1  1 = encoding found, 0 = not encodable.
REQ-010 Inverted  output  1  1 = encoding is of ~Value (MVN form).
REQ-011 Shift_operand  output  12  {rotate_imm[3:0], imm8[7:0]}; decodes as ROR(zero-extended imm8, 2*rotate_imm).

Function
REQ-012 The block SHALL be the inverse of the EXE-stage immediate Val2 decode: for ok=1, ROR({24'b0,imm8}, 2*rotate_imm) equals the target (Value, or ~Value when Inverted=1).
REQ-013 FSM states SHALL be IDLE, SEARCH, DONE; SEARCH holds a 4-bit rotation counter r and a 1-bit pass flag p.
REQ-014 IDLE + start=1: latch Value into tgt, latch Inv_En, set r=0 and p=0, go to SEARCH; start in SEARCH or DONE SHALL be ignored.
REQ-015 Each SEARCH cycle SHALL test cand = ROL(tgt, 2*r); hit iff cand[31:8]==0.
REQ-016 On hit: register Shift_operand={r,cand[7:0]}, ok=1, Inverted=p; go to DONE.
REQ-017 Miss with r<15: r increments by 1 and the block stays in SEARCH.
REQ-018 Miss with r=15, p=0, Inv_En latched 1: set tgt=~tgt, r=0, p=1; stay in SEARCH.
REQ-019 Miss with r=15 and (p=1 or latched Inv_En=0): Shift_operand=12'h000, ok=0, Inverted=0; go to DONE.
REQ-020 The smallest hitting r SHALL be reported; the pass-0 (non-inverted) encoding always takes priority.
REQ-021 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-022 ok, Inverted and Shift_operand SHALL hold their values from DONE until the next accepted start, and SHALL be cleared to 0 on the edge that accepts a start.
REQ-023 Latency, counted in rising edges from the start-accepting edge to the edge after which done=1:
  - pass-0 hit at r=k: k+1
  - pass-0 full miss without fallback: 16
  - pass-1 hit at r=k: k+17
  - pass-1 full miss: 32
REQ-024 Changes on Value or Inv_En during SEARCH SHALL NOT affect the result.
REQ-025 The minimum start-to-start period SHALL be latency+2 cycles (DONE and IDLE each occupy one cycle).

Reset
REQ-026 rst=1 at a rising edge SHALL force IDLE and set busy=0, done=0, ok=0, Inverted=0, Shift_operand=0, r=0, p=0, tgt=0, regardless of state.
REQ-027 rst asserted mid-SEARCH SHALL abort the search with no done pulse; start is ignored while rst=1.

Verification
REQ-028 Value=0x000000FF, Inv_En=0 -> done 1 edge after start, ok=1, Inverted=0, Shift_operand=0x0FF.
REQ-029 Value=0xFF000000 -> hit at r=4, done 5 edges after start, Shift_operand=0x4FF, ok=1.
REQ-030 Value=0x00000101, Inv_En=0 -> done 16 edges after start, ok=0, Shift_operand=0x000; with Inv_En=1 -> done at 32 edges, ok=0.
REQ-031 Value=0xFFFFFF00, Inv_En=1 -> done 17 edges after start, ok=1, Inverted=1, Shift_operand=0x0FF.
REQ-032 Value=0, start repeated during SEARCH and Value changed mid-search -> single done, Shift_operand=0x000, ok=1; start pulsed again in DONE is ignored.
REQ-033 rst pulsed 5 cycles into a 0x00000101 search -> no done, all outputs 0, IDLE; a new start then completes normally.
REQ-034 Random Value and Inv_En: each ok=1 result decoded as ROR(imm8, 2*rotate_imm), inverted when Inverted=1, SHALL equal Value; each ok=0 result SHALL be checked against an exhaustive reference model.

Source files
------------

// File: rtl/imm_rot_encoder_if.sv
// Handshake and result bundle for the rotated-immediate encoder.
// The master issues start/Value/Inv_En and observes status and result.
// The slave (the encoder) owns busy/done/ok/Inverted/Shift_operand.
interface imm_rot_encoder_if;
  logic        start;
  logic [31:0] Value;
  logic        Inv_En;
  logic        busy;
  logic        done;
  logic        ok;
  logic        Inverted;
  logic [11:0] Shift_operand;

  modport master (
    output start, Value, Inv_En,
    input  busy, done, ok, Inverted, Shift_operand
  );

  modport slave (
    input  start, Value, Inv_En,
    output busy, done, ok, Inverted, Shift_operand
  );
endinterface

// File: rtl/imm_rot_encoder.sv
// Finds the {rotate_imm, imm8} pair whose decode ROR({24'b0,imm8}, 2*rotate_imm)
// reproduces a 32-bit constant, optionally falling back to the inverted
// constant (MVN form). One rotation is tried per cycle, smallest first, so the
// reported encoding is always the one with the smallest rotation, and the
// non-inverted pass is always tried before the inverted one.
module imm_rot_encoder (
  input  logic               clk,
  input  logic               rst,
  imm_rot_encoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [3:0]  r_q, r_d;
  logic        p_q, p_d;
  logic        invEn_q, invEn_d;
  logic        ok_q, ok_d;
  logic        inv_q, inv_d;
  logic [11:0] shOp_q, shOp_d;

  logic [63:0] rotWide;
  logic [31:0] cand;
  logic        hit;

  // Rotating left by 2*r undoes the decoder's rotate-right; the target is
  // encodable at this r exactly when everything above the low byte is zero.
  always_comb begin
    rotWide = {tgt_q, tgt_q} << {r_q, 1'b0};
    cand    = rotWide[63:32];
    hit     = (cand[31:8] == 24'd0);
  end

  // All sequential state, with a synchronous reset that also aborts a search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= 32'd0;
      r_q     <= 4'd0;
      p_q     <= 1'b0;
      invEn_q <= 1'b0;
      ok_q    <= 1'b0;
      inv_q   <= 1'b0;
      shOp_q  <= 12'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      r_q     <= r_d;
      p_q     <= p_d;
      invEn_q <= invEn_d;
      ok_q    <= ok_d;
      inv_q   <= inv_d;
      shOp_q  <= shOp_d;
    end
  end

  // Next state and datapath: accept a request, walk the rotations, switch to
  // the inverted pass when allowed, and record the result on the way to DONE.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    r_d     = r_q;
    p_d     = p_q;
    invEn_d = invEn_q;
    ok_d    = ok_q;
    inv_d   = inv_q;
    shOp_d  = shOp_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tgt_d   = bus.Value;
          invEn_d = bus.Inv_En;
          r_d     = 4'd0;
          p_d     = 1'b0;
          ok_d    = 1'b0;
          inv_d   = 1'b0;
          shOp_d  = 12'd0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (hit) begin
          shOp_d  = {r_q, cand[7:0]};
          ok_d    = 1'b1;
          inv_d   = p_q;
          state_d = DONE;
        end else if (r_q != 4'd15) begin
          r_d = r_q + 4'd1;
        end else if (!p_q && invEn_q) begin
          tgt_d = ~tgt_q;
          r_d   = 4'd0;
          p_d   = 1'b1;
        end else begin
          shOp_d  = 12'd0;
          ok_d    = 1'b0;
          inv_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status follows the state; the result registers are held until the next
  // accepted request clears them.
  always_comb begin
    bus.busy          = (state_q == SEARCH);
    bus.done          = (state_q == DONE);
    bus.ok            = ok_q;
    bus.Inverted      = inv_q;
    bus.Shift_operand = shOp_q;
  end

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboard bench for the rotated-immediate encoder: stimulus pushes the
// expected result, a negedge monitor pops and compares on every done pulse.
module tb_imm_rot_encoder;

  typedef struct {
    logic        ok;
    logic        inv;
    logic [11:0] shOp;
    int          latency;
    int          startCycle;
    logic [31:0] value;
  } exp_t;

  logic clk;
  logic rst;
  int   cycle;
  int   checks;
  int   failures;
  exp_t scoreQ[$];

  imm_rot_encoder_if bus ();

  imm_rot_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and edge counter used to measure latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  // Decoder semantics: zero-extended byte rotated right by twice the field.
  function automatic logic [31:0] rorImm(input logic [7:0] imm, input logic [3:0] rot);
    logic [31:0] x;
    int          s;
    x = {24'd0, imm};
    s = 2 * int'(rot);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Exhaustive search over every encoding, non-inverted pass first,
  // smallest rotation first; latency follows from where the hit lands.
  function automatic exp_t refModel(input logic [31:0] v, input logic invEn);
    exp_t        e;
    logic [31:0] target;
    int          lastPass;
    e.ok         = 1'b0;
    e.inv        = 1'b0;
    e.shOp       = 12'd0;
    e.latency    = invEn ? 32 : 16;
    e.startCycle = 0;
    e.value      = v;
    lastPass     = invEn ? 1 : 0;
    for (int pass = 0; pass <= lastPass; pass++) begin
      target = (pass == 1) ? ~v : v;
      for (int rot = 0; rot < 16; rot++) begin
        for (int imm = 0; imm < 256; imm++) begin
          if (!e.ok && rorImm(imm[7:0], rot[3:0]) == target) begin
            e.ok      = 1'b1;
            e.inv     = (pass == 1);
            e.shOp    = {rot[3:0], imm[7:0]};
            e.latency = pass * 16 + rot + 1;
          end
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t mkExp(input logic ok, input logic inv, input logic [11:0] shOp,
                                 input int latency, input logic [31:0] value);
    exp_t e;
    e.ok         = ok;
    e.inv        = inv;
    e.shOp       = shOp;
    e.latency    = latency;
    e.startCycle = 0;
    e.value      = value;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] decoded;
    if (bus.done === 1'b1) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("ok", 32'(bus.ok), 32'(e.ok));
        checkOutput("inverted", 32'(bus.Inverted), 32'(e.inv));
        checkOutput("shift_operand", 32'(bus.Shift_operand), 32'(e.shOp));
        checkOutput("latency", 32'(cycle - e.startCycle), 32'(e.latency));
        checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
        if (bus.ok === 1'b1) begin
          decoded = rorImm(bus.Shift_operand[7:0], bus.Shift_operand[11:8]);
          if (bus.Inverted === 1'b1) decoded = ~decoded;
          checkOutput("decode_roundtrip", decoded, e.value);
        end
      end
    end
  end

  // Issue one request from IDLE (called #1 after a rising edge), scramble the
  // inputs during the search, wait for the result and confirm it is held.
  task automatic applyStimulus(input logic [31:0] v, input logic invEn, input exp_t e);
    int waited;
    bus.start  = 1'b1;
    bus.Value  = v;
    bus.Inv_En = invEn;
    @(posedge clk); #1;
    e.startCycle = cycle;
    scoreQ.push_back(e);
    bus.start  = 1'b0;
    bus.Value  = $urandom;
    bus.Inv_En = 1'($urandom);
    checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
    checkOutput("ok_cleared", 32'(bus.ok), 32'd0);
    checkOutput("shop_cleared", 32'(bus.Shift_operand), 32'd0);
    waited = 0;
    while (scoreQ.size() != 0 && waited < 64) begin
      @(posedge clk); #1;
      waited++;
    end
    if (scoreQ.size() != 0) begin
      checkOutput("done_timeout", 32'(waited), 32'(e.latency));
      scoreQ.delete();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      checkOutput("hold_ok", 32'(bus.ok), 32'(e.ok));
      checkOutput("hold_shop", 32'(bus.Shift_operand), 32'(e.shOp));
      checkOutput("idle_after_done", 32'(bus.busy), 32'd0);
    end
  endtask

  // Directed scenarios first, then randomized traffic against the model.
  initial begin
    logic [31:0] v;
    logic        ie;
    logic [7:0]  imm;
    logic [3:0]  rot;
    checks     = 0;
    failures   = 0;
    cycle      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.Value  = 32'd0;
    bus.Inv_En = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_ok", 32'(bus.ok), 32'd0);
    checkOutput("reset_inv", 32'(bus.Inverted), 32'd0);
    checkOutput("reset_shop", 32'(bus.Shift_operand), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(32'h000000FF, 1'b0, mkExp(1'b1, 1'b0, 12'h0FF, 1, 32'h000000FF));
    applyStimulus(32'hFF000000, 1'b0, mkExp(1'b1, 1'b0, 12'h4FF, 5, 32'hFF000000));
    applyStimulus(32'h00000101, 1'b0, mkExp(1'b0, 1'b0, 12'h000, 16, 32'h00000101));
    applyStimulus(32'h00000101, 1'b1, mkExp(1'b0, 1'b0, 12'h000, 32, 32'h00000101));
    applyStimulus(32'hFFFFFF00, 1'b1, mkExp(1'b1, 1'b1, 12'h0FF, 17, 32'hFFFFFF00));
    applyStimulus(32'hFFFFFF00, 1'b0, mkExp(1'b0, 1'b0, 12'h000, 16, 32'hFFFFFF00));

    // Start held high through SEARCH and DONE with Value changing: one result only.
    bus.start  = 1'b1;
    bus.Value  = 32'd0;
    bus.Inv_En = 1'b0;
    @(posedge clk); #1;
    scoreQ.push_back(mkExp(1'b1, 1'b0, 12'h000, 1, 32'd0));
    scoreQ[0].startCycle = cycle;
    bus.Value = 32'h12345678;
    @(posedge clk); #1;
    bus.Value = 32'hDEADBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("single_done_pending", 32'(scoreQ.size()), 32'd0);
    checkOutput("no_restart_busy", 32'(bus.busy), 32'd0);
    checkOutput("repeat_hold_ok", 32'(bus.ok), 32'd1);

    // Reset in the middle of a long search aborts it without a done pulse.
    bus.start  = 1'b1;
    bus.Value  = 32'h00000101;
    bus.Inv_En = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_ok", 32'(bus.ok), 32'd0);
    checkOutput("abort_inv", 32'(bus.Inverted), 32'd0);
    checkOutput("abort_shop", 32'(bus.Shift_operand), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_idle", 32'(bus.busy), 32'd0);
    applyStimulus(32'h0003FC00, 1'b0, mkExp(1'b1, 1'b0, 12'hBFF, 12, 32'h0003FC00));

    for (int i = 0; i < 40; i++) begin
      imm = 8'($urandom);
      rot = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = rorImm(imm, rot);
        2:       v = ~rorImm(imm, rot);
        default: v = 32'($urandom_range(0, 511)) << $urandom_range(0, 31);
      endcase
      ie = 1'($urandom);
      applyStimulus(v, ie, refModel(v, ie));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
